// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO pointer/flag controller.
package fifo_pkg;

  localparam int unsigned MEM_LENGHT_DEF      = 8;
  localparam int unsigned ADDR_WIDTH_DEF      = 3;
  localparam int unsigned MEM_WIDTH_DEF       = 10;
  localparam int unsigned ALMOST_FULL_TH_DEF  = 6;
  localparam int unsigned ALMOST_EMPTY_TH_DEF = 2;

  typedef logic [ADDR_WIDTH_DEF-1:0] ptr_t;
  typedef logic [ADDR_WIDTH_DEF:0]   count_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register; wraps to zero by natural overflow of WIDTH bits.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO pointer, count and flag controller for a registered-read memory.
// Optional sticky overflow/underflow outputs when FIFO_ERROR_FLAGS_EN is defined.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned MEM_LENGHT      = MEM_LENGHT_DEF,
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int unsigned ALMOST_FULL_TH  = ALMOST_FULL_TH_DEF,
  parameter int unsigned ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_ERROR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   fifo_count
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(MEM_LENGHT);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                afull_q, afull_d;
  logic                aempty_q, aempty_d;
  logic                dvalid_q;
  logic                do_wr, do_rd;

  // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
  assign do_wr = ~reset & push & (~full_q | pop);
  assign do_rd = ~reset & pop & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
    full_d   = (count_d == FULL_CNT);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_CNT);
    aempty_d = (count_d <= AE_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      dvalid_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      dvalid_q <= do_rd;
    end
  end

  fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (do_wr),
    .ptr_o   (write_addr)
  );

  fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (do_rd),
    .ptr_o   (read_addr)
  );

`ifdef FIFO_ERROR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (push & full_q & ~pop);
    underflow_d = underflow_q | (pop & empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign write_enable = do_wr;
  assign read_enable  = do_rd;
  assign data_valid   = dvalid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign fifo_count   = count_q;

endmodule
